// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO drain stage and its skid buffer.
package fifo_stream_pkg;

  localparam int BUF_DEPTH           = 2;
  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_COUNT_WIDTH = 16;

  typedef logic [1:0] occ_t;

  // Words already owed to the buffer (held + in flight), net of this cycle's pop.
  function automatic logic has_room(occ_t occ, logic rd_pend, logic pop);
    logic [2:0] committed;
    committed = {1'b0, occ} + {2'b00, rd_pend} - {2'b00, pop};
    return committed < 3'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port (re/empty/data_out) and valid/ready stream bundles.
interface fifo_rd_if import fifo_stream_pkg::*; #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();
  logic                  re;
  logic                  empty;
  logic [DATA_WIDTH-1:0] data;

  modport master (output re, input empty, input data);
  modport slave  (input re, output empty, output data);
endinterface

interface stream_if import fifo_stream_pkg::*; #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order buffer; head is registered and shown directly on head_data.
// push and pop may coincide; the caller never pushes into a full buffer.
module fifo_rd_skid import fifo_stream_pkg::*; #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output occ_t                  occ
);

  logic [DATA_WIDTH-1:0] ent0;
  logic [DATA_WIDTH-1:0] ent1;
  occ_t                  occ_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= '0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      if (clear) begin
        occ_q <= '0;
      end else begin
        occ_q <= occ_q + occ_t'(push) - occ_t'(pop);
      end

      if (pop) begin
        // With one entry held, a simultaneous push lands straight in the head.
        ent0 <= (push && occ_q == 2'd1) ? push_data : ent1;
        if (push && occ_q == 2'd2) begin
          ent1 <= push_data;
        end
      end else if (push) begin
        if (occ_q == 2'd0) begin
          ent0 <= push_data;
        end else begin
          ent1 <= push_data;
        end
      end
    end
  end

  assign head_data = ent0;
  assign occ       = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a FIFO with one-cycle read latency onto a valid/ready stream, 1 word/cycle.
// First word appears two cycles after re; re stalls once held + in-flight words reach two.
module fifo_stream_reader import fifo_stream_pkg::*; #(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  fifo_rd_if.master              fifo,
  input  logic                   flush,
  stream_if.master               m,
  output logic [COUNT_WIDTH-1:0] word_count
);

  occ_t                   occ;
  logic                   rd_pend;
  logic                   pop;
  logic                   push;
  logic [COUNT_WIDTH-1:0] count_q;

  assign m.valid = (occ != '0);
  assign pop     = m.valid & m.ready;

  // Gated by reset_n so no word is popped from the FIFO while we cannot hold it.
  assign fifo.re = reset_n & ~fifo.empty & ~flush & has_room(occ, rd_pend, pop);

  // Data returning in a flush cycle belongs to the discarded stream.
  assign push = rd_pend & ~flush;

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (flush),
    .push      (push),
    .push_data (fifo.data),
    .pop       (pop),
    .head_data (m.data),
    .occ       (occ)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend <= 1'b0;
      count_q <= '0;
    end else begin
      rd_pend <= fifo.re;
      count_q <= count_q + COUNT_WIDTH'(pop);
    end
  end

  assign word_count = count_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model plus a word-level scoreboard with latency tags.
module tb_fifo_stream_reader;

  localparam int DW = 32;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } word_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic [3:0]  wc_a;
  logic [15:0] wc_b;

  always #5 clk = ~clk;

  fifo_rd_if #(.DATA_WIDTH(DW)) f_a ();
  stream_if  #(.DATA_WIDTH(DW)) s_a ();
  fifo_rd_if #(.DATA_WIDTH(DW)) f_b ();
  stream_if  #(.DATA_WIDTH(DW)) s_b ();

  assign f_b.empty = f_a.empty;
  assign f_b.data  = f_a.data;
  assign s_b.ready = s_a.ready;

  fifo_stream_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fifo       (f_a),
    .flush      (flush),
    .m          (s_a),
    .word_count (wc_a)
  );

  fifo_stream_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(16)) dut16 (
    .clk        (clk),
    .reset_n    (reset_n),
    .fifo       (f_b),
    .flush      (flush),
    .m          (s_b),
    .word_count (wc_b)
  );

  logic [31:0] fifo_q[$];
  word_t       expq[$];
  word_t       dlv_log[$];
  int          re_log[$];
  int          cyc     = 0;
  logic [3:0]  cnt4    = '0;
  logic [15:0] cnt16   = '0;
  bit          gate    = 1'b0;
  bit          toggle_en = 1'b0;
  int          errors  = 0;
  int          checks  = 0;

  // One clock: check outputs at negedge against the scoreboard, then advance the FIFO model.
  task automatic tick();
    bit          exp_vld;
    bit          exp_pop;
    bit          exp_re;
    bit          did_re;
    logic [31:0] rd_word;
    word_t       e;
    rd_word = '0;
    @(negedge clk);
    exp_vld = (expq.size() > 0) && (expq[0].cyc + 2 <= cyc);
    exp_pop = exp_vld && (s_a.ready === 1'b1);
    exp_re  = (reset_n === 1'b1) && (f_a.empty === 1'b0) && (flush === 1'b0) &&
              ((expq.size() - int'(exp_pop)) < 2);
    checks++;
    if (s_a.valid !== exp_vld) begin
      errors++; $display("FAIL m_valid cyc=%0d: got %b want %b", cyc, s_a.valid, exp_vld);
    end
    if (exp_vld) begin
      checks++;
      if (s_a.data !== expq[0].data) begin
        errors++; $display("FAIL m_data cyc=%0d: got %h want %h", cyc, s_a.data, expq[0].data);
      end
    end
    checks++;
    if (f_a.re !== exp_re) begin
      errors++; $display("FAIL fifo_re cyc=%0d: got %b want %b", cyc, f_a.re, exp_re);
    end
    checks++;
    if (f_a.re === 1'b1 && f_a.empty === 1'b1) begin
      errors++; $display("FAIL underrun cyc=%0d: got re=1 while empty, want re=0", cyc);
    end
    checks++;
    if (wc_a !== cnt4) begin
      errors++; $display("FAIL word_count4 cyc=%0d: got %0d want %0d", cyc, wc_a, cnt4);
    end
    checks++;
    if (wc_b !== cnt16) begin
      errors++; $display("FAIL word_count16 cyc=%0d: got %0d want %0d", cyc, wc_b, cnt16);
    end
    checks++;
    if (s_b.valid !== exp_vld || f_b.re !== exp_re) begin
      errors++; $display("FAIL dut16 cyc=%0d: got v=%b re=%b want v=%b re=%b",
                         cyc, s_b.valid, f_b.re, exp_vld, exp_re);
    end
    if (exp_pop) begin
      e.data = expq[0].data; e.cyc = cyc;
      dlv_log.push_back(e);
      void'(expq.pop_front());
      cnt4++; cnt16++;
    end
    if (flush === 1'b1) expq.delete();
    did_re = (f_a.re === 1'b1) && (fifo_q.size() > 0);
    if (did_re) begin
      rd_word = fifo_q.pop_front();
      e.data = rd_word; e.cyc = cyc;
      expq.push_back(e);
      re_log.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    f_a.data = did_re ? rd_word : $urandom();
    if (toggle_en) gate = !gate;
    f_a.empty = (fifo_q.size() == 0) || (toggle_en && gate);
  endtask

  task automatic run_until(input int n, input int budget);
    int k = 0;
    while (dlv_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (dlv_log.size() < n) begin
      errors++; $display("FAIL timeout: got %0d deliveries want %0d", dlv_log.size(), n);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    flush = 1'b0;
    s_a.ready = 1'b0;
    toggle_en = 1'b0;
    gate = 1'b0;
    expq.delete();
    fifo_q.delete();
    cnt4 = '0; cnt16 = '0;
    f_a.empty = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    dlv_log.delete();
    re_log.delete();
  endtask

  task automatic load(input logic [31:0] w[$]);
    foreach (w[i]) fifo_q.push_back(w[i]);
    f_a.empty = (fifo_q.size() == 0) || (toggle_en && gate);
  endtask

  task automatic check_order(input string name, input logic [31:0] w[$]);
    checks++;
    if (dlv_log.size() != w.size()) begin
      errors++; $display("FAIL %s count: got %0d want %0d", name, dlv_log.size(), w.size());
    end
    for (int i = 0; i < w.size() && i < dlv_log.size(); i++) begin
      checks++;
      if (dlv_log[i].data !== w[i]) begin
        errors++; $display("FAIL %s word%0d: got %h want %h", name, i, dlv_log[i].data, w[i]);
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] w[$];
    int rel_cyc;
    for (int i = 0; i < 3; i++) w.push_back($urandom());
    reset_n = 1'b0;
    flush = 1'b0;
    s_a.ready = 1'b0;
    f_a.data = '0;
    load(w);
    repeat (2) tick();
    checks++;
    if (f_a.re !== 1'b0 || s_a.valid !== 1'b0 || wc_a !== 4'd0 || s_a.data !== 32'd0) begin
      errors++; $display("FAIL reset_state: got re=%b v=%b wc=%0d d=%h want 0 0 0 0",
                         f_a.re, s_a.valid, wc_a, s_a.data);
    end
    reset_n = 1'b1;
    rel_cyc = cyc;
    s_a.ready = 1'b1;
    dlv_log.delete(); re_log.delete();
    run_until(3, 20);
    checks++;
    if (re_log.size() == 0 || re_log[0] != rel_cyc) begin
      errors++; $display("FAIL first_re: got cyc %0d want %0d",
                         (re_log.size() > 0) ? re_log[0] : -1, rel_cyc);
    end
    check_order("reset_drain", w);
  endtask

  task automatic test_reset_mid();
    logic [31:0] w[$];
    int n;
    do_reset();
    for (int i = 0; i < 8; i++) w.push_back($urandom());
    load(w);
    s_a.ready = 1'b1;
    repeat (4) tick();
    reset_n = 1'b0;
    expq.delete();
    cnt4 = '0; cnt16 = '0;
    #1;
    checks++;
    if (s_a.valid !== 1'b0 || wc_a !== 4'd0 || wc_b !== 16'd0) begin
      errors++; $display("FAIL mid_reset: got v=%b wc=%0d/%0d want 0 0/0", s_a.valid, wc_a, wc_b);
    end
    tick();
    reset_n = 1'b1;
    n = fifo_q.size();
    w = fifo_q;
    dlv_log.delete();
    run_until(n, 30);
    check_order("mid_reset", w);
  endtask

  task automatic test_streaming();
    logic [31:0] w[$];
    do_reset();
    for (int i = 1; i <= 8; i++) w.push_back(32'(i));
    load(w);
    s_a.ready = 1'b1;
    run_until(8, 40);
    check_order("stream", w);
    for (int i = 0; i < dlv_log.size() && re_log.size() > 0; i++) begin
      checks++;
      if (dlv_log[i].cyc != re_log[0] + 2 + i) begin
        errors++; $display("FAIL stream_cyc%0d: got %0d want %0d", i, dlv_log[i].cyc, re_log[0] + 2 + i);
      end
    end
    checks++;
    if (wc_a !== 4'd8) begin
      errors++; $display("FAIL stream_count: got %0d want 8", wc_a);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w[$];
    do_reset();
    for (int i = 0; i < 4; i++) w.push_back($urandom());
    load(w);
    s_a.ready = 1'b0;
    repeat (6) tick();
    checks++;
    if (re_log.size() != 2) begin
      errors++; $display("FAIL bp_re_pulses: got %0d want 2", re_log.size());
    end
    checks++;
    if (s_a.valid !== 1'b1 || s_a.data !== w[0]) begin
      errors++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=%h", s_a.valid, s_a.data, w[0]);
    end
    s_a.ready = 1'b1;
    run_until(4, 30);
    check_order("bp_release", w);
  endtask

  task automatic test_flush();
    logic [31:0] w[$];
    logic [31:0] tail[$];
    do_reset();
    for (int i = 0; i < 4; i++) w.push_back($urandom());
    load(w);
    s_a.ready = 1'b0;
    repeat (2) tick();
    checks++;
    if (s_a.valid !== 1'b1 || re_log.size() != 2) begin
      errors++; $display("FAIL flush_setup: got v=%b reads=%0d want v=1 reads=2", s_a.valid, re_log.size());
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    s_a.ready = 1'b1;
    checks++;
    if (s_a.valid !== 1'b0) begin
      errors++; $display("FAIL flush_valid: got %b want 0", s_a.valid);
    end
    dlv_log.delete();
    tail.push_back(w[2]);
    tail.push_back(w[3]);
    run_until(2, 20);
    repeat (3) tick();
    check_order("flush_tail", tail);
  endtask

  task automatic test_empty_toggle();
    logic [31:0] w[$];
    int k = 0;
    do_reset();
    toggle_en = 1'b1;
    gate = 1'b0;
    for (int i = 0; i < 10; i++) w.push_back($urandom());
    load(w);
    while (dlv_log.size() < 10 && k < 200) begin
      s_a.ready = ($urandom_range(0, 3) != 0);
      tick();
      k++;
    end
    toggle_en = 1'b0;
    s_a.ready = 1'b1;
    repeat (4) tick();
    check_order("empty_toggle", w);
  endtask

  task automatic test_random();
    logic [31:0] w[$];
    int k = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (fifo_q.size() < 6 && $urandom_range(0, 2) == 0) begin
        w.delete();
        w.push_back($urandom());
        load(w);
      end
      gate = ($urandom_range(0, 3) == 0);
      f_a.empty = (fifo_q.size() == 0) || gate;
      s_a.ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      tick();
    end
    flush = 1'b0;
    gate = 1'b0;
    s_a.ready = 1'b1;
    f_a.empty = (fifo_q.size() == 0);
    while ((expq.size() > 0 || fifo_q.size() > 0) && k < 100) begin
      tick();
      k++;
    end
    checks++;
    if (expq.size() != 0 || dlv_log.size() < 50) begin
      errors++; $display("FAIL random_drain: got left=%0d delivered=%0d want left=0 delivered>=50",
                         expq.size(), dlv_log.size());
    end
  endtask

  task automatic test_wrap();
    logic [31:0] w[$];
    do_reset();
    for (int i = 0; i < 17; i++) w.push_back($urandom());
    load(w);
    s_a.ready = 1'b1;
    run_until(17, 60);
    checks++;
    if (wc_a !== 4'd1 || wc_b !== 16'd17) begin
      errors++; $display("FAIL wrap: got %0d/%0d want 1/17", wc_a, wc_b);
    end
    check_order("wrap", w);
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_empty_toggle();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000 want finish");
    $fatal(1, "bench timed out");
  end

endmodule
